// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter: two-master OBI data-side arbiter in front of a single
// memory port. Address phase is a combinational pass-through of the selected
// master; a small ID FIFO remembers which master owns each outstanding
// transaction so responses are routed back in order with no added latency.
// A request presented without a grant locks the selection until granted.
// Optional feature: define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on contention; otherwise m0 has fixed priority.
module obi_data_arbiter #(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,

    output logic        busy_o
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e             state_q;
    logic               lock_sel_q;
    logic               sel;
    logic               contention_sel;
    logic               req_sel;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               head;

    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic               id_q [MAX_OUTST];

`ifdef OBI_ARB_ROUND_ROBIN_EN
    // last_q = 1 means m1 was granted most recently
    logic               last_q;
    assign contention_sel = ~last_q;
`else
    assign contention_sel = 1'b0;
`endif

    // Pick the master: frozen while locked, otherwise the lone requester or the contention winner
    always_comb begin
        sel = 1'b0;
        if (state_q == LOCKED) begin
            sel = lock_sel_q;
        end else if (m0_req_i && m1_req_i) begin
            sel = contention_sel;
        end else if (m1_req_i) begin
            sel = 1'b1;
        end
    end

    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_empty = (cnt_q == '0);
    assign req_sel    = sel ? m1_req_i : m0_req_i;

    // Outputs are forced low while reset is held, even if masters keep requesting
    assign data_req_o = rst_n & req_sel & ~fifo_full;
    assign m0_gnt_o   = data_gnt_i & data_req_o & ~sel;
    assign m1_gnt_o   = data_gnt_i & data_req_o &  sel;

    // Address-phase mux; fields read as zero when no request is presented
    always_comb begin
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (data_req_o) begin
            data_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            data_we_o    = sel ? m1_we_i    : m0_we_i;
            data_be_o    = sel ? m1_be_i    : m0_be_i;
            data_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign push = data_req_o & data_gnt_i;
    // Responses arriving with nothing outstanding are dropped
    assign pop  = rst_n & data_rvalid_i & ~fifo_empty;
    assign head = id_q[rptr_q];

    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop &  head;
    assign m0_rdata_o  = data_rdata_i;
    assign m1_rdata_o  = data_rdata_i;

    assign busy_o = rst_n & (~fifo_empty | m0_req_i | m1_req_i);

    // Arbitration lock: hold the selection from an ungranted request until its grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_req_o && !data_gnt_i) begin
                        state_q    <= LOCKED;
                        lock_sel_q <= sel;
                    end
                end
                LOCKED: begin
                    if (data_gnt_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef OBI_ARB_ROUND_ROBIN_EN
    // Remember who won the last handshake; reset favours m0 first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (push) begin
            last_q <= sel;
        end
    end
`endif

    // Next-state for the ID FIFO pointers and occupancy, wrapping modulo depth
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // ID FIFO control state; reset discards every outstanding ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // ID FIFO storage; contents are only meaningful below the count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            id_q[wptr_q] <= sel;
        end
    end

endmodule
